// File: rtl/div_pkg.sv
// Shared types and constants for the 16-bit restoring divider.
// Holds the FSM state enum, datapath widths, divide-by-zero result constant,
// and a two's-complement negate helper used by the signed build.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned REM_WIDTH = DIV_WIDTH + 1;
  localparam int unsigned CNT_WIDTH = 4;

  localparam logic [CNT_WIDTH-1:0] COUNT_LAST           = 4'd15;
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Two's-complement negate at divider width.
  function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] x);
    return ~x + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/restoring_divider_16_bit_if.sv
// Start/done coprocessor bus between the ALU side (master) and the divider (slave).
// Signals:
//   start        request, accepted only while the divider is idle or done
//   dividend     numerator, sampled on the accepting edge
//   divisor      denominator, sampled on the accepting edge
//   quotient     registered result
//   remainder    registered result
//   busy         high while a division is in progress
//   done         one-cycle pulse when results update
//   div_by_zero  registered flag for the last accepted division
interface restoring_divider_16_bit_if;
  import div_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/carry_lookahead_subtractor_17_bit.sv
// 17-bit subtractor computing a + ~b + 1 with a borrow-lookahead structure.
// Bits [15:0] are split into four 4-bit groups with group propagate/generate
// feeding a lookahead unit for the group carries; bit 16 hangs off the top.
// Ports:
//   a       minuend (17 bits)
//   b       subtrahend (17 bits)
//   diff    a - b modulo 2^17
//   borrow  high when a < b (inverted final carry)
module carry_lookahead_subtractor_17_bit
  import div_pkg::*;
(
  input  logic [REM_WIDTH-1:0] a,
  input  logic [REM_WIDTH-1:0] b,
  output logic [REM_WIDTH-1:0] diff,
  output logic                 borrow
);

  logic [REM_WIDTH-1:0] p;
  logic [REM_WIDTH-1:0] g;
  logic [3:0]           gp;
  logic [3:0]           gg;
  logic [4:0]           gc;
  logic [REM_WIDTH:0]   c;

  // Bitwise propagate/generate of a + ~b.
  assign p = a ^ ~b;
  assign g = a & ~b;

  // Group propagate/generate for the four low nibbles.
  always_comb begin
    gp = '0;
    gg = '0;
    for (int grp = 0; grp < 4; grp++) begin
      gp[grp] = &p[4*grp +: 4];
      gg[grp] = g[4*grp+3]
              | (p[4*grp+3] & g[4*grp+2])
              | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
              | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp]);
    end
  end

  // Lookahead group carries; the +1 of two's complement enters as carry-in.
  assign gc[0] = 1'b1;
  assign gc[1] = gg[0] | (gp[0] & gc[0]);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & gc[0]);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

  // Per-bit carries inside each group, seeded by the lookahead group carry.
  always_comb begin
    c = '0;
    for (int grp = 0; grp < 4; grp++) begin
      c[4*grp] = gc[grp];
      for (int k = 0; k < 3; k++) begin
        c[4*grp+k+1] = g[4*grp+k] | (p[4*grp+k] & c[4*grp+k]);
      end
    end
    c[16] = gc[4];
    c[17] = g[16] | (p[16] & c[16]);
  end

  assign diff   = p ^ c[REM_WIDTH-1:0];
  assign borrow = ~c[REM_WIDTH];

endmodule

// File: rtl/restoring_divider_16_bit.sv
// 16-bit restoring divider: one trial subtraction per clock, start/done handshake.
// A division takes 16 RUN steps after the accepting edge; divide-by-zero
// completes on the accepting edge itself. Results only change on DONE entry.
// Build option: define DIV_SIGNED_EN for two's-complement operands
// (truncating division, remainder takes the dividend's sign).
// Ports:
//   clk      system clock, all state on rising edge
//   reset_n  asynchronous active-low reset; discards any in-flight division
//   bus      slave side of restoring_divider_16_bit_if
module restoring_divider_16_bit
  import div_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  restoring_divider_16_bit_if.slave  bus
);

  div_state_e           state;
  logic [CNT_WIDTH-1:0] count;
  logic [REM_WIDTH-1:0] r;
  logic [DIV_WIDTH-1:0] q;
  logic [DIV_WIDTH-1:0] d;

  logic [REM_WIDTH-1:0] r_sh;
  logic [REM_WIDTH-1:0] diff;
  logic                 borrow;
  logic [REM_WIDTH-1:0] r_step;
  logic [DIV_WIDTH-1:0] q_step;

  logic [DIV_WIDTH-1:0] dvd_mag;
  logic [DIV_WIDTH-1:0] dvs_mag;
  logic [DIV_WIDTH-1:0] quo_res;
  logic [DIV_WIDTH-1:0] rem_res;

  logic accept;

  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;

  // {R,Q} shifted left by one; R's MSB is always zero after a restored step.
  assign r_sh = REM_WIDTH'({r, q[DIV_WIDTH-1]});

  carry_lookahead_subtractor_17_bit u_sub (
    .a      (r_sh),
    .b      ({1'b0, d}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Restore on borrow, otherwise keep the trial difference and set the quotient bit.
  assign q_step = {q[DIV_WIDTH-2:0], ~borrow};
  assign r_step = borrow ? r_sh : diff;

`ifdef DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;

  assign dvd_mag = bus.dividend[DIV_WIDTH-1] ? twos_neg(bus.dividend) : bus.dividend;
  assign dvs_mag = bus.divisor[DIV_WIDTH-1]  ? twos_neg(bus.divisor)  : bus.divisor;
  assign quo_res = q_neg ? twos_neg(q_step) : q_step;
  assign rem_res = r_neg ? twos_neg(r_step[DIV_WIDTH-1:0]) : r_step[DIV_WIDTH-1:0];

  // Result signs captured alongside the operand magnitudes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept && (bus.divisor != '0)) begin
      q_neg <= bus.dividend[DIV_WIDTH-1] ^ bus.divisor[DIV_WIDTH-1];
      r_neg <= bus.dividend[DIV_WIDTH-1];
    end
  end
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
  assign quo_res = q_step;
  assign rem_res = r_step[DIV_WIDTH-1:0];
`endif

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (bus.divisor == '0) begin
              state           <= DONE;
              bus.quotient    <= DIV_BY_ZERO_QUOTIENT;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
            end else begin
              state    <= RUN;
              count    <= '0;
              r        <= '0;
              q        <= dvd_mag;
              d        <= dvs_mag;
              bus.busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        // Start is ignored here; operands and count are untouched by it.
        RUN: begin
          q     <= q_step;
          r     <= r_step;
          count <= count + CNT_WIDTH'(1);
          if (count == COUNT_LAST) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= quo_res;
            bus.remainder   <= rem_res;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
